// File: rtl/game_ctrl_pkg.sv
// Shared constants for the game frame control slice:
// sequencer state codes, unit bit indices, default watchdog limit.
package game_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_ISSUE = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;

  localparam int UNIT_BALL      = 0;
  localparam int UNIT_GADGET    = 1;
  localparam int UNIT_COLLISION = 2;

  localparam int TIMEOUT_DEFAULT = 500000;

endpackage

// File: rtl/frame_done_tracker.sv
// Per-frame done tracking: enable latch, sticky done mask,
// all-done compare and stuck-unit capture.
module frame_done_tracker #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_track,
  input  logic         i_capture,
  input  logic [N-1:0] i_en,
  input  logic [N-1:0] i_done,
  output logic         o_all_done,
  output logic [N-1:0] o_stuck
);

  logic [N-1:0] en_q;
  logic [N-1:0] mask_q;

  // Disabled units start out done so the compare ignores them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      mask_q <= '0;
    end else if (i_load) begin
      en_q   <= i_en;
      mask_q <= ~i_en;
    end else if (i_track) begin
      mask_q <= mask_q | (i_done & en_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stuck <= '0;
    end else if (i_capture) begin
      o_stuck <= ~mask_q;
    end
  end

  assign o_all_done = &mask_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: frame tick -> cal_frame, done tracking, game start.
// Optional WAIT watchdog enabled by defining FRAME_WATCHDOG_EN.
module frame_sequencer
  import game_ctrl_pkg::*;
#(
  parameter int N_UNITS        = 3,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_frame_tick,
  input  logic               i_pause,
  input  logic               i_game_start,
  input  logic [N_UNITS-1:0] i_unit_en,
  input  logic [N_UNITS-1:0] i_unit_done,
  output logic               o_cal_frame,
  output logic               o_game_start,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic [CNT_W-1:0]   o_frame_cnt,
  output logic [7:0]         o_overrun_cnt,
  output logic               o_timeout,
  output logic [N_UNITS-1:0] o_stuck_units,
  output logic [2:0]         o_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state;
  state_t nxt;
  logic   pending;
  logic   is_idle, is_start;
  logic   is_issue, is_wait;
  logic   all_done;
  logic   wd_fire;
  logic   tick_drop;
  logic   finish;

  assign is_idle   = state == ST_IDLE;
  assign is_start  = state == ST_START;
  assign is_issue  = state == ST_ISSUE;
  assign is_wait   = state == ST_WAIT;
  assign finish    = is_wait & all_done;
  assign tick_drop = i_frame_tick &
                     (is_start | is_issue | is_wait);

  frame_done_tracker #(
    .N (N_UNITS)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (is_issue),
    .i_track    (is_wait),
    .i_capture  (wd_fire),
    .i_en       (i_unit_en),
    .i_done     (i_unit_done),
    .o_all_done (all_done),
    .o_stuck    (o_stuck_units)
  );

  always_comb begin
    nxt = state;
    unique case (1'b1)
      is_idle: begin
        if (i_frame_tick) begin
          if (pending)       nxt = ST_START;
          else if (!i_pause) nxt = ST_ISSUE;
        end
      end
      is_start: nxt = ST_IDLE;
      is_issue: nxt = ST_WAIT;
      is_wait: begin
        if (all_done || wd_fire) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pending       <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_cnt   <= '0;
      o_overrun_cnt <= '0;
    end else begin
      state        <= nxt;
      pending      <= (pending & ~is_start) | i_game_start;
      o_frame_done <= finish;
      if (finish)
        o_frame_cnt <= o_frame_cnt + CNT_W'(1);
      if (tick_drop && o_overrun_cnt != 8'hff)
        o_overrun_cnt <= o_overrun_cnt + 8'd1;
    end
  end

`ifdef FRAME_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts WAIT cycles 1-based; a frame finishing on the limit still wins.
  assign wd_fire = is_wait & ~all_done &
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= wd_fire;
      if (is_issue)
        wd_cnt <= WD_W'(1);
      else if (is_wait)
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_cal_frame  = is_issue;
  assign o_game_start = is_start;
  assign o_busy       = is_issue | is_wait;
  assign o_state      = state;

endmodule
